// File: rtl/reg_chain_fpga.sv
// ============================================================================
// reg_chain_fpga : DEPTH-stage enabled register chain with fill tracking and
//                  a rotating nibble view of the oldest word.
// Revision 1.0
// ============================================================================
`default_nettype none

module reg_chain_fpga #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  parameter int NIB   = 4
) (
  input  logic                                  clk,
  input  logic                                  R,
  input  logic                                  E,
  input  logic [1:0]                            mode,
  input  logic [W-1:0]                          data,
  output logic [W-1:0]                          q,
  output logic [NIB-1:0]                        q3,
  output logic [((W/NIB) > 1 ? $clog2(W/NIB) : 1)-1:0] nib_idx,
  output logic [$clog2(DEPTH+1)-1:0]            fill,
  output logic                                  full
);

  localparam int c_NNIB = W / NIB;
  localparam int c_IW   = (c_NNIB > 1) ? $clog2(c_NNIB) : 1;
  localparam int c_FW   = $clog2(DEPTH + 1);

  localparam logic [1:0] c_MODE_HOLD  = 2'b00;
  localparam logic [1:0] c_MODE_LOAD  = 2'b01;
  localparam logic [1:0] c_MODE_ROT   = 2'b10;
  localparam logic [1:0] c_MODE_CLEAR = 2'b11;

  localparam logic [c_FW-1:0] c_FILL_MAX = c_FW'(DEPTH);
  localparam logic [c_IW-1:0] c_NIB_LAST = c_IW'(c_NNIB - 1);

  logic [1:0]       r_rst_sync;
  logic             rst_n;
  logic [W-1:0]     r_stage [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [c_FW-1:0]  r_fill;
  logic [c_IW-1:0]  r_nib;

  // Assertion follows R immediately; deassertion is aligned to clk.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign rst_n = r_rst_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
      r_valid <= '0;
      r_fill  <= '0;
      r_nib   <= '0;
    end else if (E) begin
      case (mode)
        c_MODE_LOAD: begin
          r_stage[0] <= data;
          r_valid[0] <= 1'b1;
          for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
            r_valid[i] <= r_valid[i-1];
          end
          if (r_fill != c_FILL_MAX) begin
            r_fill <= r_fill + 1'b1;
          end
          // A new oldest word is always shown starting from its low nibble.
          r_nib <= '0;
        end
        c_MODE_ROT: begin
          if (r_nib == c_NIB_LAST) begin
            r_nib <= '0;
          end else begin
            r_nib <= r_nib + 1'b1;
          end
        end
        c_MODE_CLEAR: begin
          for (int i = 0; i < DEPTH; i++) begin
            r_stage[i] <= '0;
          end
          r_valid <= '0;
          r_fill  <= '0;
          r_nib   <= '0;
        end
        c_MODE_HOLD: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign q       = r_stage[DEPTH-1];
  assign q3      = q[r_nib*NIB +: NIB];
  assign nib_idx = r_nib;
  assign fill    = r_fill;
  // The last valid bit is set exactly when every stage holds a loaded word.
  assign full    = r_valid[DEPTH-1];

endmodule

`default_nettype wire

// File: tb/tb_reg_chain_fpga.sv
// ============================================================================
// tb_reg_chain_fpga : directed self-checking bench for reg_chain_fpga
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_reg_chain_fpga;

  logic        clk;
  logic        R;
  logic        E;
  logic [1:0]  mode;
  logic [63:0] data;
  logic [63:0] q;
  logic [3:0]  q3;
  logic [3:0]  nib_idx;
  logic [2:0]  fill;
  logic        full;

  logic        E2;
  logic [1:0]  mode2;
  logic [7:0]  data2;
  logic [7:0]  q_b;
  logic [3:0]  q3_b;
  logic [0:0]  nib_b;
  logic [0:0]  fill_b;
  logic        full_b;

  int errors = 0;
  int checks = 0;

  reg_chain_fpga #(.W(64), .DEPTH(4), .NIB(4)) dut (
    .clk(clk), .R(R), .E(E), .mode(mode), .data(data),
    .q(q), .q3(q3), .nib_idx(nib_idx), .fill(fill), .full(full)
  );

  reg_chain_fpga #(.W(8), .DEPTH(1), .NIB(4)) dut1 (
    .clk(clk), .R(R), .E(E2), .mode(mode2), .data(data2),
    .q(q_b), .q3(q3_b), .nib_idx(nib_b), .fill(fill_b), .full(full_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's worth of inputs, then sample 1 ns after the edge.
  task automatic step(input logic e, input logic [1:0] m, input logic [63:0] d);
    E = e; mode = m; data = d;
    @(posedge clk);
    #1;
    E = 1'b0; mode = 2'b00;
  endtask

  task automatic step1(input logic e, input logic [1:0] m, input logic [7:0] d);
    E2 = e; mode2 = m; data2 = d;
    @(posedge clk);
    #1;
    E2 = 1'b0; mode2 = 2'b00;
  endtask

  task automatic release_reset();
    R = 1'b1;
    repeat (3) step(1'b0, 2'b00, 64'h0);
  endtask

  task automatic test_reset();
    #2 R = 1'b0;
    #1;
    checks++; if (q !== 64'h0) begin errors++; $display("FAIL reset_q got=%h exp=0", q); end
    checks++; if (q3 !== 4'h0) begin errors++; $display("FAIL reset_q3 got=%h exp=0", q3); end
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL reset_fill got=%0d exp=0", fill); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (nib_idx !== 4'd0) begin errors++; $display("FAIL reset_nib got=%0d exp=0", nib_idx); end
    checks++; if (q_b !== 8'h0 || full_b !== 1'b0) begin errors++; $display("FAIL reset_d1 got q=%h full=%b exp 0/0", q_b, full_b); end
    release_reset();
  endtask

  task automatic test_latency();
    step(1'b1, 2'b01, 64'h1111_1111_1111_1111);
    checks++; if (q !== 64'h0) begin errors++; $display("FAIL lat_q1 got=%h exp=0", q); end
    checks++; if (fill !== 3'd1 || full !== 1'b0) begin errors++; $display("FAIL lat_fill1 got=%0d/%b exp=1/0", fill, full); end
    step(1'b1, 2'b01, 64'h2222_2222_2222_2222);
    step(1'b1, 2'b00, 64'h0);
    step(1'b1, 2'b10, 64'h0);
    step(1'b1, 2'b01, 64'h3333_3333_3333_3333);
    checks++; if (q !== 64'h0) begin errors++; $display("FAIL lat_q3 got=%h exp=0", q); end
    step(1'b1, 2'b01, 64'h4444_4444_4444_4444);
    checks++; if (q !== 64'h1111_1111_1111_1111) begin errors++; $display("FAIL lat_q4 got=%h exp=1111111111111111", q); end
    checks++; if (fill !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL lat_fill4 got=%0d/%b exp=4/1", fill, full); end
    checks++; if (nib_idx !== 4'd0) begin errors++; $display("FAIL lat_nib got=%0d exp=0", nib_idx); end
    step(1'b1, 2'b01, 64'h5555_5555_5555_5555);
    checks++; if (q !== 64'h2222_2222_2222_2222) begin errors++; $display("FAIL lat_q5 got=%h exp=2222222222222222", q); end
    checks++; if (fill !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL lat_sat got=%0d/%b exp=4/1", fill, full); end
  endtask

  task automatic test_rotate();
    logic [63:0] word;
    logic [3:0]  exp_n;
    word = 64'h0123_4567_89AB_CDEF;
    step(1'b1, 2'b11, 64'h0);
    checks++; if (q !== 64'h0 || fill !== 3'd0) begin errors++; $display("FAIL clr_pre got=%h/%0d exp=0/0", q, fill); end
    step(1'b1, 2'b01, word);
    step(1'b1, 2'b01, 64'hB0);
    step(1'b1, 2'b01, 64'hC0);
    step(1'b1, 2'b01, 64'hD0);
    checks++; if (q3 !== 4'hF) begin errors++; $display("FAIL rot_start got=%h exp=f", q3); end
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 2'b10, 64'h0);
      exp_n = 4'(15 - (k % 16));
      checks++;
      if (q3 !== exp_n || nib_idx !== 4'(k % 16)) begin
        errors++; $display("FAIL rot_%0d got q3=%h idx=%0d exp q3=%h idx=%0d", k, q3, nib_idx, exp_n, k % 16);
      end
    end
    checks++; if (q !== word) begin errors++; $display("FAIL rot_q got=%h exp=%h", q, word); end
    step(1'b1, 2'b10, 64'h0);
  endtask

  task automatic test_enable();
    for (int k = 0; k < 3; k++) step(1'b0, 2'b01, 64'hFF);
    checks++; if (q !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL en_q got=%h exp=0123456789abcdef", q); end
    checks++; if (nib_idx !== 4'd1 || q3 !== 4'hE) begin errors++; $display("FAIL en_nib got=%0d/%h exp=1/e", nib_idx, q3); end
    checks++; if (fill !== 3'd4) begin errors++; $display("FAIL en_fill got=%0d exp=4", fill); end
    step(1'b1, 2'b01, 64'hE0);
    checks++; if (q !== 64'hB0 || nib_idx !== 4'd0) begin errors++; $display("FAIL en_shift got=%h/%0d exp=b0/0", q, nib_idx); end
  endtask

  task automatic test_clear();
    step(1'b1, 2'b11, 64'h0);
    step(1'b1, 2'b01, 64'h77);
    step(1'b1, 2'b01, 64'h88);
    for (int k = 0; k < 5; k++) step(1'b1, 2'b10, 64'h0);
    checks++; if (nib_idx !== 4'd5 || fill !== 3'd2) begin errors++; $display("FAIL clr_pre got=%0d/%0d exp=5/2", nib_idx, fill); end
    step(1'b1, 2'b11, 64'h0);
    checks++; if (q !== 64'h0 || fill !== 3'd0 || nib_idx !== 4'd0 || full !== 1'b0) begin
      errors++; $display("FAIL clr_all got q=%h fill=%0d idx=%0d full=%b exp all 0", q, fill, nib_idx, full);
    end
    step(1'b1, 2'b10, 64'h0);
    checks++; if (nib_idx !== 4'd1 || q3 !== 4'h0) begin errors++; $display("FAIL clr_emptyrot got=%0d/%h exp=1/0", nib_idx, q3); end
    step(1'b1, 2'b01, 64'h99);
    checks++; if (fill !== 3'd1 || nib_idx !== 4'd0 || q !== 64'h0) begin errors++; $display("FAIL clr_load got=%0d/%0d/%h exp=1/0/0", fill, nib_idx, q); end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 2'b01, 64'hAA);
    step(1'b1, 2'b01, 64'hBB);
    step(1'b1, 2'b01, 64'hCC);
    step(1'b1, 2'b10, 64'h0);
    checks++; if (q !== 64'h99 || fill !== 3'd4) begin errors++; $display("FAIL mid_pre got=%h/%0d exp=99/4", q, fill); end
    #2 R = 1'b0;
    #1;
    checks++; if (q !== 64'h0 || q3 !== 4'h0 || fill !== 3'd0 || full !== 1'b0 || nib_idx !== 4'd0) begin
      errors++; $display("FAIL mid_reset got q=%h q3=%h fill=%0d full=%b idx=%0d exp all 0", q, q3, fill, full, nib_idx);
    end
    release_reset();
    step(1'b1, 2'b01, 64'h12);
    checks++; if (fill !== 3'd1) begin errors++; $display("FAIL mid_after got=%0d exp=1", fill); end
  endtask

  task automatic test_depth1();
    step1(1'b1, 2'b01, 8'hA5);
    checks++; if (q_b !== 8'hA5 || full_b !== 1'b1 || fill_b !== 1'b1) begin errors++; $display("FAIL d1_load got=%h/%b/%0d exp=a5/1/1", q_b, full_b, fill_b); end
    checks++; if (q3_b !== 4'h5) begin errors++; $display("FAIL d1_q3_0 got=%h exp=5", q3_b); end
    step1(1'b1, 2'b10, 8'h00);
    checks++; if (q3_b !== 4'hA || nib_b !== 1'b1) begin errors++; $display("FAIL d1_rot1 got=%h/%0d exp=a/1", q3_b, nib_b); end
    step1(1'b1, 2'b10, 8'h00);
    checks++; if (q3_b !== 4'h5 || nib_b !== 1'b0) begin errors++; $display("FAIL d1_rot2 got=%h/%0d exp=5/0", q3_b, nib_b); end
    step1(1'b1, 2'b10, 8'h00);
    step1(1'b1, 2'b01, 8'h3C);
    checks++; if (q_b !== 8'h3C || nib_b !== 1'b0 || fill_b !== 1'b1) begin errors++; $display("FAIL d1_load2 got=%h/%0d/%0d exp=3c/0/1", q_b, nib_b, fill_b); end
  endtask

  initial begin
    R = 1'b1; E = 1'b0; mode = 2'b00; data = '0;
    E2 = 1'b0; mode2 = 2'b00; data2 = '0;
    test_reset();
    test_latency();
    test_rotate();
    test_enable();
    test_clear();
    test_reset_mid();
    test_depth1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
